tcm_banked_ram: RTL and testbench

//  Multi-port, bank-interleaved tightly-coupled memory with byte-enable writes and req/gnt/rvalid handshake.

---
 rtl/tcm_banked_ram.sv | 155 +++++++++++++++
 tb/tb_tcm_banked_ram.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/tcm_banked_ram.sv
// Multi-port, word-interleaved banked TCM with per-bank round-robin arbitration,
// byte-enable writes, req/gnt/rvalid handshake and out-of-range error responses.
module tcm_banked_ram #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_BYTES  = 4096,
    parameter int NUM_BANKS  = 2,
    parameter int NUM_PORTS  = 2,
    parameter int READ_LAT   = 1
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [NUM_PORTS-1:0]                   req_i,
    output logic [NUM_PORTS-1:0]                   gnt_o,
    input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]   addr_i,
    input  logic [NUM_PORTS-1:0]                   we_i,
    input  logic [NUM_PORTS-1:0][DATA_WIDTH/8-1:0] be_i,
    input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]   wdata_i,
    output logic [NUM_PORTS-1:0]                   rvalid_o,
    output logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]   rdata_o,
    output logic [NUM_PORTS-1:0]                   err_o
);

    localparam int BYTES     = DATA_WIDTH / 8;
    localparam int OFF_W     = $clog2(BYTES);
    localparam int WORDS     = NUM_BYTES / BYTES;
    localparam int DEPTH     = WORDS / NUM_BANKS;
    localparam int LOG_BANKS = $clog2(NUM_BANKS);
    localparam int BANK_W    = (NUM_BANKS > 1) ? LOG_BANKS : 1;
    localparam int ROW_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PORT_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [ADDR_WIDTH-1:0] BANK_MASK = ADDR_WIDTH'(NUM_BANKS - 1);

    logic [DATA_WIDTH-1:0] r_mem [NUM_BANKS][DEPTH];
    logic [PORT_W-1:0]     r_rr  [NUM_BANKS];

    logic [ADDR_WIDTH-1:0] w_word [NUM_PORTS];
    logic [BANK_W-1:0]     w_bank [NUM_PORTS];
    logic [ROW_W-1:0]      w_row  [NUM_PORTS];
    logic [DATA_WIDTH-1:0] w_rd   [NUM_PORTS];
    logic [NUM_PORTS-1:0]  w_oor;
    logic [NUM_PORTS-1:0]  w_gnt;
    logic [NUM_BANKS-1:0]  w_bank_hit;
    logic [PORT_W-1:0]     w_bank_win [NUM_BANKS];

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_word[p] = addr_i[p] >> OFF_W;
            w_oor[p]  = 32'(w_word[p]) >= 32'(WORDS);
            w_bank[p] = BANK_W'(w_word[p] & BANK_MASK);
            w_row[p]  = ROW_W'(w_word[p] >> LOG_BANKS);
            w_rd[p]   = r_mem[w_bank[p]][w_row[p]];
        end
    end

    // Round-robin search per bank, starting at r_rr[b]; out-of-range requests never compete.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        w_bank_hit = '0;
        w_gnt      = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            w_bank_win[b] = '0;
            for (int k = 0; k < NUM_PORTS; k++) begin : search
                int idx;
                idx = (int'(r_rr[b]) + k) % NUM_PORTS;
                if (rst_n && !w_bank_hit[b] && req_i[idx] && !w_oor[idx] &&
                    w_bank[idx] == BANK_W'(b)) begin
                    w_bank_hit[b] = 1'b1;
                    w_bank_win[b] = PORT_W'(idx);
                end
            end
        end
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_gnt[p] = rst_n && req_i[p] &&
                       (w_oor[p] || (w_bank_hit[w_bank[p]] && int'(w_bank_win[w_bank[p]]) == p));
        end
    end

    assign gnt_o = w_gnt;

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < NUM_BANKS; b++) r_rr[b] <= '0;
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (w_bank_hit[b]) begin
                    r_rr[b] <= (int'(w_bank_win[b]) == NUM_PORTS - 1) ? '0
                                                                      : w_bank_win[b] + PORT_W'(1);
                end
            end
        end
    end

    // NOTE: the array has no reset so it can map onto SRAM macros; contents survive rst_n.
    always_ff @(posedge clk) begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (w_bank_hit[b] && we_i[w_bank_win[b]]) begin
                for (int i = 0; i < BYTES; i++) begin
                    if (be_i[w_bank_win[b]][i]) begin
                        r_mem[b][w_row[w_bank_win[b]]][8*i +: 8] <= wdata_i[w_bank_win[b]][8*i +: 8];
                    end
                end
            end
        end
    end

    logic [NUM_PORTS-1:0]                 r_v1;
    logic [NUM_PORTS-1:0]                 r_err1;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] r_d1;

    // Data registers only load on a response so rdata_o holds between responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1   <= '0;
            r_err1 <= '0;
            r_d1   <= '0;
        end else begin
            r_v1   <= w_gnt;
            r_err1 <= w_gnt & w_oor;
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (w_gnt[p]) r_d1[p] <= (we_i[p] || w_oor[p]) ? '0 : w_rd[p];
            end
        end
    end

    if (READ_LAT == 2) begin : g_lat2
        logic [NUM_PORTS-1:0]                 r_v2;
        logic [NUM_PORTS-1:0]                 r_err2;
        logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] r_d2;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_v2   <= '0;
                r_err2 <= '0;
                r_d2   <= '0;
            end else begin
                r_v2   <= r_v1;
                r_err2 <= r_err1;
                for (int p = 0; p < NUM_PORTS; p++) begin
                    if (r_v1[p]) r_d2[p] <= r_d1[p];
                end
            end
        end

        assign rvalid_o = r_v2;
        assign err_o    = r_err2;
        assign rdata_o  = r_d2;
    end else begin : g_lat1
        assign rvalid_o = r_v1;
        assign err_o    = r_err1;
        assign rdata_o  = r_d1;
    end

endmodule

// File: tb/tb_tcm_banked_ram.sv
// Directed bench: a cycle table for the READ_LAT=1 instance plus hand sequences
// for READ_LAT=2 pipelining and mid-flight reset.
module tb_tcm_banked_ram;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [1:0]        req, we, gnt, rvalid, err;
    logic [1:0][15:0]  addr;
    logic [1:0][3:0]   be;
    logic [1:0][31:0]  wdata, rdata;

    logic [1:0]        req2, we2, gnt2, rvalid2, err2;
    logic [1:0][15:0]  addr2;
    logic [1:0][3:0]   be2;
    logic [1:0][31:0]  wdata2, rdata2;

    tcm_banked_ram #(.READ_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req), .gnt_o(gnt), .addr_i(addr), .we_i(we),
        .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err)
    );

    tcm_banked_ram #(.READ_LAT(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .req_i(req2), .gnt_o(gnt2), .addr_i(addr2), .we_i(we2),
        .be_i(be2), .wdata_i(wdata2), .rvalid_o(rvalid2), .rdata_o(rdata2), .err_o(err2)
    );

    typedef struct {
        logic [1:0]  req;
        logic [1:0]  we;
        logic [15:0] a0, a1;
        logic [3:0]  be0, be1;
        logic [31:0] d0, d1;
        logic [1:0]  gnt, rv, err;
        logic [31:0] r0, r1;
    } vec_t;

    vec_t vt [16];
    int   n_vec  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        req = '0; we = '0; addr = '0; be = '0; wdata = '0;
        req2 = '0; we2 = '0; addr2 = '0; be2 = '0; wdata2 = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    logic [31:0] exp2 [6];

    initial begin
        // {req, we, a0, a1, be0, be1, d0, d1, gnt, rvalid, err, rdata0, rdata1}
        vt[0]  = '{2'b01, 2'b01, 16'h0010, 16'h0000, 4'hF, 4'h0, 32'hDEADBEEF, 32'h0, 2'b01, 2'b01, 2'b00, 32'h0, 32'h0};
        vt[1]  = '{2'b01, 2'b01, 16'h0010, 16'h0000, 4'h2, 4'h0, 32'h00005500, 32'h0, 2'b01, 2'b01, 2'b00, 32'h0, 32'h0};
        vt[2]  = '{2'b01, 2'b00, 16'h0010, 16'h0000, 4'h0, 4'h0, 32'h0, 32'h0, 2'b01, 2'b01, 2'b00, 32'hDEAD55EF, 32'h0};
        vt[3]  = '{2'b11, 2'b11, 16'h0000, 16'h0004, 4'hF, 4'hF, 32'h11111111, 32'h22222222, 2'b11, 2'b11, 2'b00, 32'h0, 32'h0};
        vt[4]  = '{2'b11, 2'b10, 16'h0000, 16'h0004, 4'h0, 4'h0, 32'h0, 32'h33333333, 2'b11, 2'b11, 2'b00, 32'h11111111, 32'h0};
        vt[5]  = '{2'b10, 2'b00, 16'h0000, 16'h0004, 4'h0, 4'h0, 32'h0, 32'h0, 2'b10, 2'b10, 2'b00, 32'h11111111, 32'h22222222};
        vt[6]  = '{2'b10, 2'b10, 16'h0000, 16'h0008, 4'h0, 4'hF, 32'h0, 32'h88888888, 2'b10, 2'b10, 2'b00, 32'h11111111, 32'h0};
        vt[7]  = '{2'b11, 2'b00, 16'h0000, 16'h0008, 4'h0, 4'h0, 32'h0, 32'h0, 2'b01, 2'b01, 2'b00, 32'h11111111, 32'h0};
        vt[8]  = '{2'b11, 2'b00, 16'h0000, 16'h0008, 4'h0, 4'h0, 32'h0, 32'h0, 2'b10, 2'b10, 2'b00, 32'h11111111, 32'h88888888};
        vt[9]  = '{2'b11, 2'b00, 16'h0000, 16'h0008, 4'h0, 4'h0, 32'h0, 32'h0, 2'b01, 2'b01, 2'b00, 32'h11111111, 32'h88888888};
        vt[10] = '{2'b11, 2'b00, 16'h0000, 16'h0008, 4'h0, 4'h0, 32'h0, 32'h0, 2'b10, 2'b10, 2'b00, 32'h11111111, 32'h88888888};
        vt[11] = '{2'b11, 2'b01, 16'h2000, 16'h0000, 4'hF, 4'h0, 32'h12345678, 32'h0, 2'b11, 2'b11, 2'b01, 32'h0, 32'h11111111};
        vt[12] = '{2'b01, 2'b00, 16'h0000, 16'h0000, 4'h0, 4'h0, 32'h0, 32'h0, 2'b01, 2'b01, 2'b00, 32'h11111111, 32'h11111111};
        vt[13] = '{2'b11, 2'b10, 16'h1000, 16'h0FFC, 4'h0, 4'hF, 32'h0, 32'hA5A5A5A5, 2'b11, 2'b11, 2'b01, 32'h0, 32'h0};
        vt[14] = '{2'b10, 2'b00, 16'h0000, 16'h0FFE, 4'h0, 4'h0, 32'h0, 32'h0, 2'b10, 2'b10, 2'b00, 32'h0, 32'hA5A5A5A5};
        vt[15] = '{2'b00, 2'b00, 16'h0000, 16'h0000, 4'h0, 4'h0, 32'h0, 32'h0, 2'b00, 2'b00, 2'b00, 32'h0, 32'hA5A5A5A5};

        // Reset state, with requests pending to confirm gnt stays low.
        idle();
        rst_n = 1'b0;
        req   = 2'b11;
        req2  = 2'b11;
        #12;
        check("reset gnt",        32'(gnt),      32'h0);
        check("reset gnt lat2",   32'(gnt2),     32'h0);
        check("reset rvalid",     32'(rvalid),   32'h0);
        check("reset err",        32'(err),      32'h0);
        check("reset rdata0",     rdata[0],      32'h0);
        check("reset rdata1",     rdata[1],      32'h0);
        check("reset rvalid lat2", 32'(rvalid2), 32'h0);
        @(negedge clk);
        idle();
        rst_n = 1'b1;

        // Table: READ_LAT=1 instance, one vector per cycle.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            req = vt[i].req; we = vt[i].we;
            addr[0] = vt[i].a0;  addr[1] = vt[i].a1;
            be[0] = vt[i].be0;   be[1] = vt[i].be1;
            wdata[0] = vt[i].d0; wdata[1] = vt[i].d1;
            #1;
            check($sformatf("v%0d gnt", i), 32'(gnt), 32'(vt[i].gnt));
            @(posedge clk);
            #1;
            check($sformatf("v%0d rvalid", i), 32'(rvalid), 32'(vt[i].rv));
            check($sformatf("v%0d err", i),    32'(err),    32'(vt[i].err));
            check($sformatf("v%0d rdata0", i), rdata[0],    vt[i].r0);
            check($sformatf("v%0d rdata1", i), rdata[1],    vt[i].r1);
        end
        @(negedge clk);
        idle();

        // READ_LAT=2: three writes then three back-to-back reads on port 0.
        exp2[0] = 32'h0; exp2[1] = 32'h0; exp2[2] = 32'h0;
        exp2[3] = 32'h0A0A0A0A; exp2[4] = 32'h0B0B0B0B; exp2[5] = 32'h0C0C0C0C;
        for (int j = 0; j < 9; j++) begin
            @(negedge clk);
            if (j < 6) begin
                req2[0]  = 1'b1;
                we2[0]   = (j < 3);
                addr2[0] = 16'(4 * (j % 3));
                be2[0]   = 4'hF;
                wdata2[0] = (j < 3) ? exp2[j + 3] : 32'h0;
            end else begin
                idle();
            end
            #1;
            check($sformatf("lat2 c%0d gnt", j), 32'(gnt2), (j < 6) ? 32'h1 : 32'h0);
            @(posedge clk);
            #1;
            check($sformatf("lat2 c%0d rvalid", j), 32'(rvalid2), (j >= 1 && j <= 6) ? 32'h1 : 32'h0);
            check($sformatf("lat2 c%0d err", j),    32'(err2),    32'h0);
            if (j >= 1 && j <= 6) check($sformatf("lat2 c%0d rdata", j), rdata2[0], exp2[j - 1]);
        end

        // Reset right after a read grant: both instances must drop and not respond later.
        @(negedge clk);
        req[0] = 1'b1;  addr[0] = 16'h0010;
        req2[0] = 1'b1; addr2[0] = 16'h0004;
        @(posedge clk);
        #1;
        check("pre-reset rvalid",      32'(rvalid),  32'h1);
        check("pre-reset rdata",       rdata[0],     32'hDEAD55EF);
        check("pre-reset rvalid lat2", 32'(rvalid2), 32'h0);
        rst_n = 1'b0;
        #1;
        check("in-reset rvalid", 32'(rvalid), 32'h0);
        check("in-reset rdata0", rdata[0],    32'h0);
        check("in-reset gnt",    32'(gnt),    32'h0);
        @(negedge clk);
        @(negedge clk);
        idle();
        rst_n = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(posedge clk);
            #1;
            check($sformatf("post-reset c%0d rvalid", j),      32'(rvalid),  32'h0);
            check($sformatf("post-reset c%0d rvalid lat2", j), 32'(rvalid2), 32'h0);
        end

        // Memory contents survive reset.
        @(negedge clk);
        req[0] = 1'b1;  addr[0] = 16'h0010;
        req2[0] = 1'b1; addr2[0] = 16'h0004;
        @(posedge clk);
        #1;
        check("after-reset rvalid", 32'(rvalid), 32'h1);
        check("after-reset rdata",  rdata[0],    32'hDEAD55EF);
        @(negedge clk);
        idle();
        @(posedge clk);
        #1;
        check("after-reset rvalid lat2", 32'(rvalid2), 32'h1);
        check("after-reset rdata lat2",  rdata2[0],    32'h0B0B0B0B);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
